// File: rtl/dmem_port_arbiter.sv
// Data-port (port B) arbiter for the unified memory: round-robin between core and debug,
// lane/byte-enable generation on stores, aligned and extended load data one cycle after grant.
module dmem_port_arbiter #(
  parameter int unsigned WADDR_W = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [1:0]  core_size,
  input  logic        core_uns,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [1:0]  dbg_size,
  input  logic        dbg_uns,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        core_gnt,
  output logic        dbg_gnt,
  output logic        core_rvalid,
  output logic        dbg_rvalid,
  output logic [31:0] core_rdata,
  output logic [31:0] dbg_rdata,
  output logic        core_err,
  output logic        dbg_err,
  output logic [16:0] mem_address,
  output logic [3:0]  mem_byteena,
  output logic [31:0] mem_data,
  output logic        mem_enable,
  output logic        mem_wren,
  input  logic [31:0] mem_q
);
  localparam int unsigned MAW       = 17;
  localparam int unsigned RANGE_LSB = WADDR_W + 2;

  typedef enum logic {OWN_CORE = 1'b0, OWN_DBG = 1'b1} owner_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    owner_e      owner;
    logic        valid;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic        err;
  } rsp_t;

  owner_e      last_q, last_d;
  rsp_t        rsp_q, rsp_d;
  acc_t        sel;
  logic        any_req, pick_dbg;
  logic        is_byte, is_half, misal, oor, acc_err;
  logic [7:0]  b_sel;
  logic [15:0] h_sel;
  logic [31:0] fmt_data;

  // Round-robin: on a tie the requester not granted last wins; no grants while in reset.
  always_comb begin : arbitrate
    any_req  = reset_n && (core_req || dbg_req);
    pick_dbg = dbg_req && (!core_req || (last_q == OWN_CORE));
    core_gnt = any_req && !pick_dbg;
    dbg_gnt  = any_req && pick_dbg;
    sel      = pick_dbg ? {dbg_we, dbg_size, dbg_uns, dbg_addr, dbg_wdata}
                        : {core_we, core_size, core_uns, core_addr, core_wdata};
    last_d   = last_q;
    if (any_req) begin
      last_d = pick_dbg ? OWN_DBG : OWN_CORE;
    end
  end

  always_comb begin : access_check
    is_byte = (sel.size == 2'b00);
    is_half = (sel.size == 2'b01);
    misal   = (is_half && sel.addr[0]) || (!is_byte && !is_half && (sel.addr[1:0] != 2'b00));
    oor     = (sel.addr >> RANGE_LSB) != 32'h0;
    acc_err = misal || oor;
  end

  // Port B is only strobed for a clean access in its grant cycle; otherwise all zeros.
  always_comb begin : mem_port
    mem_address = '0;
    mem_byteena = '0;
    mem_data    = '0;
    mem_enable  = 1'b0;
    mem_wren    = 1'b0;
    if (any_req && !acc_err) begin
      mem_address = MAW'(sel.addr[WADDR_W+1:2]);
      if (!sel.we) begin
        mem_enable  = 1'b1;
        mem_byteena = 4'b1111;
      end else begin
        mem_wren = 1'b1;
        if (is_byte) begin
          mem_byteena = 4'b0001 << sel.addr[1:0];
          mem_data    = {4{sel.wdata[7:0]}};
        end else if (is_half) begin
          mem_byteena = sel.addr[1] ? 4'b1100 : 4'b0011;
          mem_data    = {2{sel.wdata[15:0]}};
        end else begin
          mem_byteena = 4'b1111;
          mem_data    = sel.wdata;
        end
      end
    end
  end

  always_comb begin : rsp_next
    rsp_d = '0;
    if (any_req) begin
      rsp_d.owner = pick_dbg ? OWN_DBG : OWN_CORE;
      rsp_d.valid = 1'b1;
      rsp_d.we    = sel.we;
      rsp_d.size  = sel.size;
      rsp_d.uns   = sel.uns;
      rsp_d.off   = sel.addr[1:0];
      rsp_d.err   = acc_err;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= OWN_DBG;
      rsp_q  <= '0;
    end else begin
      last_q <= last_d;
      rsp_q  <= rsp_d;
    end
  end

  // Lane select and extension of the registered memory word; stores and errors return 0.
  always_comb begin : load_format
    b_sel = mem_q[{rsp_q.off, 3'b000} +: 8];
    h_sel = mem_q[{rsp_q.off[1], 4'b0000} +: 16];
    case (rsp_q.size)
      2'b00:   fmt_data = {{24{!rsp_q.uns && b_sel[7]}}, b_sel};
      2'b01:   fmt_data = {{16{!rsp_q.uns && h_sel[15]}}, h_sel};
      default: fmt_data = mem_q;
    endcase
    if (rsp_q.we || rsp_q.err) begin
      fmt_data = '0;
    end
  end

  always_comb begin : rsp_out
    core_rvalid = rsp_q.valid && (rsp_q.owner == OWN_CORE);
    dbg_rvalid  = rsp_q.valid && (rsp_q.owner == OWN_DBG);
    core_rdata  = core_rvalid ? fmt_data : '0;
    dbg_rdata   = dbg_rvalid ? fmt_data : '0;
    core_err    = core_rvalid && rsp_q.err;
    dbg_err     = dbg_rvalid && rsp_q.err;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: byte-level reference memory, queue of expected
// responses, and a behavioural port-B memory driving mem_q.
module tb_dmem_port_arbiter;
  localparam int unsigned WADDR_W = 16;
  localparam logic P_CORE = 1'b0;
  localparam logic P_DBG  = 1'b1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_req, core_we, core_uns, dbg_req, dbg_we, dbg_uns;
  logic [1:0]  core_size, dbg_size;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic        core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, core_err, dbg_err;
  logic [31:0] core_rdata, dbg_rdata, mem_data;
  logic [31:0] mem_q = 32'h0;
  logic [16:0] mem_address;
  logic [3:0]  mem_byteena;
  logic        mem_enable, mem_wren;

  dmem_port_arbiter #(.WADDR_W(WADDR_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_size(core_size), .core_uns(core_uns),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size), .dbg_uns(dbg_uns),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .core_gnt(core_gnt), .dbg_gnt(dbg_gnt), .core_rvalid(core_rvalid), .dbg_rvalid(dbg_rvalid),
    .core_rdata(core_rdata), .dbg_rdata(dbg_rdata), .core_err(core_err), .dbg_err(dbg_err),
    .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
    .mem_enable(mem_enable), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t expq[$];
  txn_t cr, dr;
  logic last_m;
  logic [31:0] envm [int unsigned];
  logic [7:0]  refm [int unsigned];

  always @(posedge clock) cyc <= cyc + 1;

  // Port-B memory: byte-lane writes and registered reads, both at the clock edge.
  always @(posedge clock) begin : env_mem
    int unsigned idx;
    logic [31:0] w;
    idx = 32'(mem_address);
    w = envm.exists(idx) ? envm[idx] : 32'h0;
    if (mem_wren) begin
      for (int l = 0; l < 4; l++) if (mem_byteena[l]) w[8*l +: 8] = mem_data[8*l +: 8];
      envm[idx] = w;
    end
    if (mem_enable) mem_q <= w;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic acc_bad(input txn_t t);
    return ((t.addr % nbytes(t.size)) != 0) || (t.addr >= (32'd1 << (WADDR_W + 2)));
  endfunction

  function automatic logic [7:0] rd_byte(input int unsigned a);
    return refm.exists(a) ? refm[a] : 8'h0;
  endfunction

  // Reference: stores update bytes at grant; loads assemble little-endian bytes then extend.
  task automatic execute(input txn_t t, output logic [31:0] data, output logic err);
    int unsigned n;
    longint unsigned v;
    err  = acc_bad(t);
    data = 32'h0;
    n    = nbytes(t.size);
    if (!err) begin
      if (t.we) begin
        for (int unsigned i = 0; i < n; i++) refm[t.addr + i] = t.wdata[8*i +: 8];
      end else begin
        v = 0;
        for (int unsigned i = 0; i < n; i++) v |= longint'(rd_byte(t.addr + i)) << (8 * i);
        if (!t.uns && n < 4 && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 1);
        data = v[31:0];
      end
    end
  endtask

  function automatic logic [54:0] exp_port(input logic won, input txn_t t);
    int unsigned n, m;
    logic [16:0] a17;
    logic [31:0] d;
    if (!won || acc_bad(t)) return '0;
    a17 = 17'(t.addr >> 2);
    if (!t.we) return {a17, 4'hF, 32'h0, 1'b1, 1'b0};
    n = nbytes(t.size);
    m = ((32'd1 << n) - 1) << (t.addr % 4);
    d = (n == 1) ? 32'(t.wdata[7:0]) * 32'h01010101 :
        (n == 2) ? 32'(t.wdata[15:0]) * 32'h00010001 : t.wdata;
    return {a17, 4'(m), d, 1'b0, 1'b1};
  endfunction

  function automatic txn_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.v = 1'b1; t.we = we; t.size = size; t.uns = uns; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t mk_rand();
    txn_t t;
    int unsigned off, nb;
    t.v = 1'b1;
    t.we = 1'($urandom % 2);
    t.size = 2'($urandom % 4);
    t.uns = 1'($urandom % 2);
    nb = nbytes(t.size);
    off = $urandom % 4;
    if ($urandom % 4 != 0) off = off - (off % nb);
    t.addr = 32'h40 + 32'($urandom % 8) * 4 + 32'(off);
    if ($urandom % 16 == 0) t.addr |= 32'd1 << (18 + ($urandom % 14));
    t.wdata = $urandom;
    return t;
  endfunction

  // One cycle: drive pending requests, check grant and port-B encoding, record expectation.
  task automatic step();
    logic anyr, won_dbg, er;
    logic [31:0] d;
    txn_t w;
    exp_t e;
    core_req = cr.v; core_we = cr.we; core_size = cr.size; core_uns = cr.uns;
    core_addr = cr.addr; core_wdata = cr.wdata;
    dbg_req = dr.v; dbg_we = dr.we; dbg_size = dr.size; dbg_uns = dr.uns;
    dbg_addr = dr.addr; dbg_wdata = dr.wdata;
    @(negedge clock);
    anyr = cr.v || dr.v;
    if (cr.v && dr.v) won_dbg = (last_m == P_CORE);
    else won_dbg = dr.v;
    chk("gnt", 64'({core_gnt, dbg_gnt}), 64'({anyr && !won_dbg, anyr && won_dbg}));
    w = won_dbg ? dr : cr;
    chk("memport", 64'({mem_address, mem_byteena, mem_data, mem_enable, mem_wren}),
        64'(exp_port(anyr, w)));
    if (anyr) begin
      execute(w, d, er);
      e.port = won_dbg; e.data = d; e.err = er; e.cyc = cyc;
      expq.push_back(e);
      last_m = won_dbg;
      if (won_dbg) dr.v = 1'b0;
      else cr.v = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops the oldest expectation whenever a response is presented.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n) begin
      while (expq.size() > 0 && expq[0].cyc + 1 < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_rvalid grant_cycle=%0d now=%0d", expq[0].cyc, cyc);
        void'(expq.pop_front());
      end
      if (core_rvalid || dbg_rvalid) begin
        if (expq.size() == 0) begin
          chk("spurious_rvalid", 64'({core_rvalid, dbg_rvalid}), 64'(2'b00));
        end else begin
          e = expq.pop_front();
          chk("rvalid_port", 64'({core_rvalid, dbg_rvalid}), e.port ? 64'(2'b01) : 64'(2'b10));
          chk("latency", 64'(cyc), 64'(e.cyc + 1));
          chk("rdata", 64'(e.port ? dbg_rdata : core_rdata), 64'(e.data));
          chk("err", 64'(e.port ? dbg_err : core_err), 64'(e.err));
        end
      end
      chk("nonowner_quiet", 64'({core_rvalid ? 33'h0 : {core_err, core_rdata},
                                 dbg_rvalid ? 33'h0 : {dbg_err, dbg_rdata}}), 64'h0);
    end
  end

  task automatic chk_reset_outputs();
    chk("reset_ctl", 64'({core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, core_err, dbg_err,
                          mem_enable, mem_wren, mem_byteena, mem_address}), 64'h0);
    chk("reset_data", {core_rdata, dbg_rdata}, 64'h0);
    chk("reset_memdata", 64'(mem_data), 64'h0);
  endtask

  initial begin
    cr = mk(0, 0, 0, 0, 0); cr.v = 1'b0;
    dr = cr;
    last_m = P_DBG;
    envm[32'h100] = 32'h8899AABB;
    refm[32'h400] = 8'hBB; refm[32'h401] = 8'hAA; refm[32'h402] = 8'h99; refm[32'h403] = 8'h88;
    core_req = 1'b1; dbg_req = 1'b1; core_we = 1'b0; dbg_we = 1'b0;
    core_size = 2'b10; dbg_size = 2'b10; core_uns = 1'b0; dbg_uns = 1'b0;
    core_addr = 32'h400; dbg_addr = 32'h400; core_wdata = 32'h0; dbg_wdata = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs();
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Continuous contention from reset: must alternate core, dbg, ...
    for (int i = 0; i < 8; i++) begin
      if (!cr.v) cr = mk(0, 2'b10, 0, 32'h400, 0);
      if (!dr.v) dr = mk(0, 2'b00, 1'(i % 2), 32'h401 + 32'(i % 3), 0);
      step();
    end
    cr.v = 1'b0; dr.v = 1'b0;
    step();

    cr = mk(0, 2'b00, 0, 32'h401, 0);           step();
    cr = mk(0, 2'b00, 1, 32'h401, 0);           step();
    cr = mk(0, 2'b01, 0, 32'h402, 0);           step();
    cr = mk(1, 2'b00, 0, 32'h403, 32'h5A);      step();
    cr = mk(1, 2'b01, 0, 32'h400, 32'h1234);    step();
    cr = mk(0, 2'b10, 0, 32'h400, 0);           step();
    cr = mk(0, 2'b10, 0, 32'h402, 0);           step();
    cr = mk(1, 2'b10, 0, 32'h0004_0000, 32'hCAFEF00D); step();
    cr = mk(0, 2'b10, 0, 32'h0, 0);             step();
    cr = mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF); step();
    cr = mk(0, 2'b10, 0, 32'h10, 0);            step();
    dr = mk(1, 2'b11, 0, 32'h14, 32'h01020304); step();
    dr = mk(0, 2'b01, 1, 32'h16, 0);            step();
    step();

    for (int i = 0; i < 400; i++) begin
      if (cr.v && ($urandom % 10 == 0)) cr.v = 1'b0;
      if (dr.v && ($urandom % 10 == 0)) dr.v = 1'b0;
      if (!cr.v && ($urandom % 4 != 0)) cr = mk_rand();
      if (!dr.v && ($urandom % 4 != 0)) dr = mk_rand();
      step();
    end
    cr.v = 1'b0; dr.v = 1'b0;
    step(); step();

    // Reset in the cycle after a load grant drops that response.
    cr = mk(0, 2'b10, 0, 32'h400, 0);
    step();
    reset_n = 1'b0;
    expq.delete();
    last_m = P_DBG;
    core_req = 1'b0; dbg_req = 1'b0;
    @(negedge clock);
    chk_reset_outputs();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cr = mk(0, 2'b10, 0, 32'h400, 0);
    dr = mk(0, 2'b10, 0, 32'h10, 0);
    step();
    step();
    step(); step();
    chk("drain", 64'(expq.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
